// File: rtl/dff_rr_arbiter_if.sv
// Request/data/grant bundle for dff_rr_arbiter. The arbiter uses the slave
// modport, and the producers driving req and d use the master modport.
interface dff_rr_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] d;
  logic [N-1:0]       gnt;
  logic [WIDTH-1:0]   q;
  logic               q_valid;
  logic [PW-1:0]      owner;

  modport master (
    output req, d,
    input  gnt, q, q_valid, owner
  );

  modport slave (
    input  req, d,
    output gnt, q, q_valid, owner
  );
endinterface

// File: rtl/dff_rr_arbiter.sv
// Round-robin write arbiter. N requesters share one WIDTH-bit register, and
// each grant loads the winner's data slice and issues a one-cycle gnt pulse.
module dff_rr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  dff_rr_arbiter_if.slave   bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    win;
  logic             found;
  logic [N-1:0]     gnt_r, gnt_nxt;
  logic [WIDTH-1:0] q_r, q_nxt;
  logic             q_valid_r, q_valid_nxt;
  logic [PW-1:0]    owner_r, owner_nxt;

  // First set request starting at ptr and wrapping modulo N (N need not be a power of 2).
  always_comb begin : search
    int unsigned idx;
    idx   = 0;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < unsigned'(N); k++) begin
      idx = k + 32'(ptr);
      if (idx >= unsigned'(N)) idx = idx - unsigned'(N);
      if (!found && bus.req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gnt_nxt     = '0;
    q_nxt       = q_r;
    q_valid_nxt = q_valid_r;
    owner_nxt   = owner_r;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = GRANT;
          gnt_nxt[win] = 1'b1;
          owner_nxt    = win;
          q_valid_nxt  = 1'b1;
          ptr_nxt      = (win == PW'(N - 1)) ? '0 : win + PW'(1);
          for (int unsigned i = 0; i < unsigned'(N); i++) begin
            if (win == PW'(i)) q_nxt = bus.d[i*WIDTH +: WIDTH];
          end
        end
      end
      GRANT: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_r     <= '0;
      q_r       <= '0;
      q_valid_r <= 1'b0;
      owner_r   <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt_r     <= gnt_nxt;
      q_r       <= q_nxt;
      q_valid_r <= q_valid_nxt;
      owner_r   <= owner_nxt;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.q       = q_r;
  assign bus.q_valid = q_valid_r;
  assign bus.owner   = owner_r;
endmodule
